// File: rtl/prefetch_pkg.sv
// rtl/prefetch_pkg.sv - shared constants and types for the prefetch responder
package prefetch_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  // Address the prefetcher emits when it has nothing to fetch
  localparam logic [DEF_ADDR_W-1:0] NULL_ADDR = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } fsm_state_t;

  typedef struct packed {
    logic                  valid;
    logic [DEF_ADDR_W-1:0] tag;
    logic [DEF_DATA_W-1:0] data;
  } pb_entry_t;

endpackage

// File: rtl/req_fifo.sv
// rtl/req_fifo.sv - prefetch request queue with associative duplicate match
module req_fifo
  import prefetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              pop,
  output logic [ADDR_W-1:0] head_addr,
  output logic              full,
  output logic              empty,
  input  logic [ADDR_W-1:0] match_addr,
  output logic              match
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  vld;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic              do_pop;
  logic              do_push;

  // A per-slot valid bit keeps full/empty and the match scan trivial
  assign full      = &vld;
  assign empty     = ~|vld;
  assign head_addr = mem[head];
  assign do_pop    = pop && !empty;
  // A full queue still takes a push when the head leaves in the same cycle
  assign do_push   = push && (!full || do_pop);

  // Pointer and occupancy update; a push landing on the slot just popped wins
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      vld  <= '0;
    end else begin
      if (do_pop) begin
        vld[head] <= 1'b0;
        head      <= head + 1'b1;
      end
      if (do_push) begin
        vld[tail] <= 1'b1;
        tail      <= tail + 1'b1;
      end
    end
  end

  // Payload storage needs no reset; validity is tracked separately
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[tail] <= push_addr;
    end
  end

  // Compare the probe address against every occupied slot
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (mem[i] == match_addr)) begin
        match = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prefetch_responder.sv
// rtl/prefetch_responder.sv - queues prefetches, fetches them, serves demand probes
module prefetch_responder
  import prefetch_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int QDEPTH     = 4,
  parameter int PB_ENTRIES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_drop,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  input  logic              lookup_valid,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              lookup_hit,
  output logic [DATA_W-1:0] lookup_data,
  output logic              busy
);

  localparam int PB_IW = (PB_ENTRIES > 1) ? $clog2(PB_ENTRIES) : 1;

  fsm_state_t        state;
  fsm_state_t        state_nxt;
  logic [ADDR_W-1:0] inflight_addr;

  pb_entry_t         pb [PB_ENTRIES];
  logic [PB_IW-1:0]  rr_ptr;

  logic              q_full;
  logic              q_empty;
  logic              q_match;
  logic [ADDR_W-1:0] q_head;
  logic              q_pop;

  logic              accept;
  logic              inflight_dup;
  logic              tag_dup;
  logic              push_want;
  logic              fill;
  logic              lk_match;
  logic              lk_take;
  logic [PB_IW-1:0]  lk_idx;
  logic              any_free;
  logic [PB_IW-1:0]  free_idx;
  logic [PB_IW-1:0]  victim;

  req_fifo #(
    .ADDR_W (ADDR_W),
    .DEPTH  (QDEPTH)
  ) u_req_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_want),
    .push_addr  (req_addr),
    .pop        (q_pop),
    .head_addr  (q_head),
    .full       (q_full),
    .empty      (q_empty),
    .match_addr (req_addr),
    .match      (q_match)
  );

  // Duplicate checks all look at registered state, so same-cycle pushes,
  // pops and fills never influence them
  assign accept       = req_valid && (req_addr != NULL_ADDR);
  assign inflight_dup = (state != IDLE) && (inflight_addr == req_addr);
  assign push_want    = accept && !q_match && !inflight_dup && !tag_dup;
  assign lk_take      = lookup_valid && lk_match;
  assign victim       = any_free ? free_idx : rr_ptr;
  assign busy         = !q_empty || (state != IDLE);

  // Scan the buffer once for the duplicate tag, the probe hit and the lowest free slot
  always_comb begin
    tag_dup  = 1'b0;
    lk_match = 1'b0;
    lk_idx   = '0;
    any_free = 1'b0;
    free_idx = '0;
    for (int i = PB_ENTRIES - 1; i >= 0; i--) begin
      if (pb[i].valid) begin
        if (pb[i].tag == req_addr) begin
          tag_dup = 1'b1;
        end
        if (pb[i].tag == lookup_addr) begin
          lk_match = 1'b1;
          lk_idx   = PB_IW'(i);
        end
      end else begin
        any_free = 1'b1;
        free_idx = PB_IW'(i);
      end
    end
  end

  // Next-state and memory-port drive for the one-outstanding-request FSM
  always_comb begin
    state_nxt     = state;
    q_pop         = 1'b0;
    fill          = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr  = NULL_ADDR;
    case (state)
      IDLE: begin
        if (!q_empty) begin
          q_pop     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = inflight_addr;
        if (mem_req_ready) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          fill      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; the popped head becomes the in-flight address
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      inflight_addr <= '0;
    end else begin
      state <= state_nxt;
      if (q_pop) begin
        inflight_addr <= q_head;
      end
    end
  end

  // Registered drop pulse for a non-duplicate request that found the queue full
  always_ff @(posedge clk) begin
    if (rst) begin
      req_drop <= 1'b0;
    end else begin
      req_drop <= push_want && q_full && !q_pop;
    end
  end

  // Buffer update: a hit consumes its entry, a fill writes the victim, fill wins on overlap
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PB_ENTRIES; i++) begin
        pb[i] <= '0;
      end
      rr_ptr      <= '0;
      lookup_hit  <= 1'b0;
      lookup_data <= '0;
    end else begin
      lookup_hit  <= lk_take;
      lookup_data <= lk_take ? pb[lk_idx].data : '0;
      if (lk_take) begin
        pb[lk_idx].valid <= 1'b0;
      end
      if (fill) begin
        pb[victim] <= '{valid: 1'b1, tag: inflight_addr, data: mem_resp_data};
        if (!any_free) begin
          rr_ptr <= (rr_ptr == PB_IW'(PB_ENTRIES - 1)) ? '0 : rr_ptr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_prefetch_responder.sv
// tb/tb_prefetch_responder.sv - directed and random checks against a transaction model
module tb_prefetch_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        req_drop;
  logic        mem_req_valid;
  logic [15:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [15:0] mem_resp_data;
  logic        lookup_valid;
  logic [15:0] lookup_addr;
  logic        lookup_hit;
  logic [15:0] lookup_data;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // reference model: request queue, phase (0 idle, 1 requesting, 2 awaiting data), buffer slots
  logic [15:0] mq[$];
  int          ph;
  logic [15:0] inf;
  bit          bv[8];
  logic [15:0] bt[8];
  logic [15:0] bd[8];
  int          rr;
  logic        e_drop;
  logic        e_hit;
  logic [15:0] e_data;

  logic [15:0] hs[$];
  int          drops;
  bit          auto_resp;

  always #5 clk = ~clk;

  prefetch_responder dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_drop       (req_drop),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .lookup_valid   (lookup_valid),
    .lookup_addr    (lookup_addr),
    .lookup_hit     (lookup_hit),
    .lookup_data    (lookup_data),
    .busy           (busy)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit acc, dup, pop, fill, lhit, anyfree;
    int li, victim, qsz;
    if (rst) begin
      mq.delete();
      ph = 0; inf = 16'h0; rr = 0;
      for (int i = 0; i < 8; i++) bv[i] = 1'b0;
      e_drop = 1'b0; e_hit = 1'b0; e_data = 16'h0;
      return;
    end
    qsz = mq.size();
    acc = req_valid && (req_addr != 16'hFFFF);
    dup = 1'b0;
    foreach (mq[i]) if (mq[i] == req_addr) dup = 1'b1;
    if (ph != 0 && inf == req_addr) dup = 1'b1;
    for (int i = 0; i < 8; i++) if (bv[i] && bt[i] == req_addr) dup = 1'b1;
    pop = (ph == 0) && (qsz > 0);
    lhit = 1'b0; li = 0;
    if (lookup_valid)
      for (int i = 0; i < 8; i++) if (bv[i] && bt[i] == lookup_addr) begin lhit = 1'b1; li = i; end
    e_hit  = lhit;
    e_data = lhit ? bd[li] : 16'h0;
    fill = (ph == 2) && mem_resp_valid;
    anyfree = 1'b0; victim = rr;
    for (int i = 7; i >= 0; i--) if (!bv[i]) begin anyfree = 1'b1; victim = i; end
    if (lhit) bv[li] = 1'b0;
    if (fill) begin
      bv[victim] = 1'b1; bt[victim] = inf; bd[victim] = mem_resp_data;
      if (!anyfree) rr = (rr + 1) % 8;
    end
    e_drop = acc && !dup && (qsz == 4) && !pop;
    case (ph)
      0: if (pop) begin inf = mq.pop_front(); ph = 1; end
      1: if (mem_req_ready) ph = 2;
      default: if (mem_resp_valid) ph = 0;
    endcase
    if (acc && !dup && (qsz < 4 || pop)) mq.push_back(req_addr);
  endtask

  task automatic step();
    bit          hs_now;
    logic [15:0] hs_addr;
    hs_now  = mem_req_valid && mem_req_ready && !rst;
    hs_addr = mem_req_addr;
    if (hs_now) hs.push_back(hs_addr);
    model_edge();
    @(posedge clk);
    #1;
    if (req_drop) drops++;
    chk("req_drop", req_drop, e_drop);
    chk("mem_req_valid", mem_req_valid, ph == 1);
    chk("mem_req_addr", mem_req_addr, (ph == 1) ? inf : 16'hFFFF);
    chk("busy", busy, (mq.size() > 0) || (ph != 0));
    chk("lookup_hit", lookup_hit, e_hit);
    chk("lookup_data", lookup_data, e_data);
    if (auto_resp) begin
      mem_resp_valid = hs_now;
      mem_resp_data  = hs_addr ^ 16'hA5A5;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = 16'h0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_data = 16'h0; lookup_valid = 1'b0; lookup_addr = 16'h0;
    auto_resp = 1'b0; drops = 0;
    for (int i = 0; i < 8; i++) begin bv[i] = 1'b0; bt[i] = 16'h0; bd[i] = 16'h0; end
    ph = 0; inf = 16'h0; rr = 0;
    #1;
    do_reset();
    chk("rst_busy", busy, 16'h0);
    chk("rst_mem_req_addr", mem_req_addr, 16'hFFFF);

    // single request round trip
    mem_req_ready = 1'b1;
    req_valid = 1'b1; req_addr = 16'h0040; step();
    req_valid = 1'b0; step();
    chk("single_issue_valid", mem_req_valid, 16'h1);
    chk("single_issue_addr", mem_req_addr, 16'h0040);
    step();
    mem_resp_valid = 1'b1; mem_resp_data = 16'hBEEF; step();
    mem_resp_valid = 1'b0;
    lookup_valid = 1'b1; lookup_addr = 16'h0040; step();
    chk("single_hit", lookup_hit, 16'h1);
    chk("single_data", lookup_data, 16'hBEEF);
    step();
    chk("single_rehit", lookup_hit, 16'h0);
    lookup_valid = 1'b0;

    // duplicate suppression
    hs.delete(); drops = 0; auto_resp = 1'b1;
    req_valid = 1'b1; req_addr = 16'h0100;
    for (int i = 0; i < 3; i++) step();
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("dup_handshakes", 16'(hs.size()), 16'd1);
    chk("dup_drops", 16'(drops), 16'd0);

    // overflow with memory stalled, then drain in order
    auto_resp = 1'b0; mem_resp_valid = 1'b0; mem_req_ready = 1'b0;
    hs.delete(); drops = 0;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1; req_addr = 16'h0300 + 16'(i); step();
    end
    req_valid = 1'b0;
    chk("ovf_drops", 16'(drops), 16'd1);
    mem_req_ready = 1'b1; auto_resp = 1'b1;
    for (int i = 0; i < 25; i++) step();
    chk("ovf_handshakes", 16'(hs.size()), 16'd5);
    for (int i = 0; i < 5; i++) chk("ovf_order", hs[i], 16'h0300 + 16'(i));
    chk("ovf_idle", busy, 16'h0);

    // replacement after nine fills
    do_reset();
    for (int k = 0; k < 9; k++) begin
      req_valid = 1'b1; req_addr = 16'h0400 + 16'(k); step();
      req_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
    end
    lookup_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      lookup_addr = 16'h0400 + 16'(k); step();
      chk("repl_hit", lookup_hit, (k == 0) ? 16'h0 : 16'h1);
      chk("repl_data", lookup_data, (k == 0) ? 16'h0 : ((16'h0400 + 16'(k)) ^ 16'hA5A5));
    end
    lookup_valid = 1'b0;

    // lookup in the same cycle as the fill
    auto_resp = 1'b0; mem_resp_valid = 1'b0;
    req_valid = 1'b1; req_addr = 16'h0200; step();
    req_valid = 1'b0; step(); step();
    mem_resp_valid = 1'b1; mem_resp_data = 16'h1234;
    lookup_valid = 1'b1; lookup_addr = 16'h0200; step();
    chk("fill_same_cycle_hit", lookup_hit, 16'h0);
    mem_resp_valid = 1'b0; step();
    chk("fill_next_hit", lookup_hit, 16'h1);
    chk("fill_next_data", lookup_data, 16'h1234);
    lookup_valid = 1'b0;

    // reset while waiting for data
    req_valid = 1'b1; req_addr = 16'h0500; step();
    req_valid = 1'b0; step(); step();
    rst = 1'b1; step();
    rst = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 16'h7777; step();
    mem_resp_valid = 1'b0;
    chk("rw_busy", busy, 16'h0);
    chk("rw_mem_req_valid", mem_req_valid, 16'h0);
    chk("rw_mem_req_addr", mem_req_addr, 16'hFFFF);
    chk("rw_drop", req_drop, 16'h0);
    lookup_valid = 1'b1; lookup_addr = 16'h0500; step();
    chk("rw_no_fill", lookup_hit, 16'h0);
    lookup_valid = 1'b0;

    // randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      rst            = ($urandom_range(0, 299) == 0);
      req_valid      = $urandom_range(0, 1);
      req_addr       = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'h0010 + 16'($urandom_range(0, 11));
      mem_req_ready  = ($urandom_range(0, 2) != 0);
      mem_resp_valid = ($urandom_range(0, 4) < 2);
      mem_resp_data  = 16'($urandom);
      lookup_valid   = ($urandom_range(0, 4) < 2);
      lookup_addr    = 16'h0010 + 16'($urandom_range(0, 11));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prefetch_responder.md
# prefetch_responder

Memory-side responder for the stride prefetcher's request stream. Accepts fire-and-forget prefetch addresses, discards duplicates, queues the rest, issues them one at a time to the memory port, and stores returned data in a small fully-associative prefetch buffer. The load path probes that buffer with demand addresses. Sits between the prefetcher's `submitMemRequest`/`requestAddress` outputs and main memory.

## Interface
- `ADDR_W`, 16: address width.
- `DATA_W`, 16: data word width.
- `QDEPTH`, 4: request queue depth, a power of two.
- `PB_ENTRIES`, 8: prefetch buffer entries.
- `clk` in 1: the single clock. All logic is on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `req_valid` in 1: prefetch request strobe. There is no backpressure.
- `req_addr` in ADDR_W: prefetch address. `16'hFFFF` is the null address.
- `req_drop` out 1: one-cycle pulse when a request is discarded because the queue is full.
- `mem_req_valid` out 1 / `mem_req_addr` out ADDR_W / `mem_req_ready` in 1: memory request handshake.
- `mem_resp_valid` in 1 / `mem_resp_data` in DATA_W: memory response. Responses arrive in order, and at most one request is outstanding.
- `lookup_valid` in 1 / `lookup_addr` in ADDR_W: demand probe.
- `lookup_hit` out 1 / `lookup_data` out DATA_W: registered probe result.
- `busy` out 1: high when the queue is non-empty or the FSM is not in IDLE.

## Operation
- **Request acceptance.** A request is accepted when `req_valid` is high and `req_addr` is not `16'hFFFF`. An accepted request is silently ignored, with no `req_drop`, if its address matches any of:
  - a valid queue entry,
  - the in-flight address, while the FSM is in ISSUE or WAIT,
  - a valid buffer tag.
- **Enqueue.** Otherwise the request is pushed into the queue. If the queue is full and no pop happens in the same cycle, the request is dropped and `req_drop` pulses. A push and a pop in the same cycle on a full queue both succeed.
- **FSM states:**
  - **IDLE.** If the queue is non-empty, pop the head into `inflight_addr` and go to ISSUE.
  - **ISSUE.** Drive `mem_req_valid = 1` and `mem_req_addr = inflight_addr`. When `mem_req_ready` is high, go to WAIT.
  - **WAIT.** When `mem_resp_valid` is high, fill the buffer with `{inflight_addr, mem_resp_data}` and go to IDLE.
- `mem_resp_valid` is ignored outside WAIT.
- **Fill victim.** The victim is the lowest-index invalid entry. If all entries are valid, the victim is the entry at the round-robin pointer, and the pointer then increments modulo `PB_ENTRIES`.
- **Lookup.** On `lookup_valid`, a tag match on a valid entry gives `lookup_hit = 1` and `lookup_data` = the entry's data, and the entry is invalidated (the hit consumes it). On a miss, `lookup_hit = 0` and `lookup_data = 0`. A lookup with `lookup_valid = 0` also yields `0`/`0`.
- **Simultaneous events:**
  - A lookup sees the buffer state from before any fill in the same cycle, so probing the address being filled misses.
  - Duplicate checks see the state from before same-cycle pushes, pops and fills.
- **Reset.** Clears the queue, all valid bits, the round-robin pointer and `inflight_addr`, and returns the FSM to IDLE.
  - Reset applies even mid-ISSUE or mid-WAIT; the abandoned response is ignored because the FSM is then in IDLE.
  - Reset values of outputs: `req_drop = 0`, `mem_req_valid = 0`, `mem_req_addr = 16'hFFFF`, `lookup_hit = 0`, `lookup_data = 0`, `busy = 0`.

## Timing
- **Request to memory.** A request sampled at edge E0 is written to the queue at E0. The FSM pops at E1 and enters ISSUE, so `mem_req_valid` is high from E1 onward: best case is 2 edges from request to memory.
- **Memory handshake.** The handshake completes at the first edge where `mem_req_valid` and `mem_req_ready` are both high. `mem_req_valid` drops after that edge, and the address is held stable while waiting for `mem_req_ready`.
- **Fill.** `mem_resp_valid` sampled at edge En writes the entry at En. A lookup sampled at En+1 hits.
- **Lookup latency.** 1 cycle: `lookup_hit` and `lookup_data` are valid after the sampling edge and held for one cycle.
- **Drop pulse.** `req_drop` is registered and is high for the cycle after the dropped request.
- **Throughput.** At most one memory transaction per 3 cycles (IDLE → ISSUE → WAIT). The queue absorbs bursts.

## Structure
- Package `prefetch_pkg` holds:
  - `ADDR_W` and `DATA_W` defaults,
  - `NULL_ADDR = 16'hFFFF`,
  - the FSM state enum (`IDLE`, `ISSUE`, `WAIT`),
  - the buffer entry struct `{valid, tag, data}`.
- Sub-module `req_fifo`: a synchronous FIFO with head/tail pointers, full/empty flags, and a combinational `match` output that compares an input address against all valid entries. The top level owns the FSM, the prefetch buffer, and the lookup path.

## Test plan
- **Single request.** Send `req_addr = 0x0040`; hold `mem_req_ready = 1`; return `mem_resp_data = 0xBEEF` 3 cycles later. Then lookup `0x0040` → `lookup_hit = 1`, `lookup_data = 0xBEEF`. Repeat the lookup → `lookup_hit = 0`.
- **Duplicate suppression.** Send `0x0100` on 3 consecutive cycles → exactly one `mem_req_valid` handshake and no `req_drop`.
- **Queue overflow.** Hold `mem_req_ready = 0`; send 6 distinct addresses → 1 in flight, 4 queued, and `req_drop` pulses exactly once. Release `mem_req_ready` → 5 memory requests issued in order.
- **Replacement.** Fill 9 distinct addresses with no lookups → the first address misses, and the others hit with the correct data.
- **Lookup during fill.** A lookup of `0x0200` in the same cycle as its `mem_resp_valid` misses; a lookup one cycle later hits.
- **Reset mid-WAIT.** Assert `rst` while in WAIT, then pulse `mem_resp_valid` → no fill, `busy = 0`, and every output is at its reset value.
